// File: rtl/i2s_pkg.sv
// Shared I2S constants: sample width, slot/frame geometry and counter widths.
package i2s_pkg;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned BITCNT_W   = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = 8;
endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock generator: divider, registered sck and a falling-edge strobe.
module i2s_sck_gen
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic sck,
  output logic fall_c
);

  logic [DIV_W-1:0] div_q;
  logic             tc_c;

  assign tc_c   = (div_q == DIV_W'(CLK_DIV - 1));
  // Strobe is high on the cycle whose edge drives sck from 1 to 0.
  assign fall_c = tc_c && sck;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      sck   <= 1'b0;
    end else if (tc_c) begin
      div_q <= '0;
      sck   <= ~sck;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_transmit.sv
// I2S master transmitter: one-deep sample-pair holding register feeding a
// 64-bit-per-frame serializer with one-bit data delay and underrun reporting.
module i2s_transmit
  import i2s_pkg::SLOT_BITS, i2s_pkg::BITCNT_W;
#(
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned DATA_W  = i2s_pkg::DATA_W
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_left,
  input  logic [DATA_W-1:0] data_right,
  output logic              sck,
  output logic              ws,
  output logic              sd,
  output logic              underrun
);

  localparam int unsigned SLOT_W = $clog2(SLOT_BITS);

  logic                  fall_c;
  logic                  load_c;
  logic                  accept_c;
  logic [BITCNT_W-1:0]   bitcnt_q;
  logic [BITCNT_W-1:0]   bitcnt_inc_c;
  logic [SLOT_W-1:0]     slot_bit_c;
  logic [2*DATA_W-1:0]   shreg_q;
  logic [2*DATA_W-1:0]   shreg_nxt;
  logic                  hold_full_q;
  logic                  hold_full_nxt;
  logic [DATA_W-1:0]     hold_l_q;
  logic [DATA_W-1:0]     hold_r_q;
  logic                  ws_nxt;
  logic                  sd_nxt;
  logic                  underrun_nxt;

  i2s_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk    (CLOCK_50),
    .rst_n  (resetn),
    .sck    (sck),
    .fall_c (fall_c)
  );

  assign accept_c     = in_valid && in_ready;
  assign load_c       = fall_c && (bitcnt_q == '1);
  assign bitcnt_inc_c = bitcnt_q + BITCNT_W'(1);
  assign slot_bit_c   = bitcnt_inc_c[SLOT_W-1:0];

  // Serializer next state; acceptance is applied after the load so a pair
  // arriving on the load cycle is held for the following frame.
  always_comb begin
    shreg_nxt     = shreg_q;
    hold_full_nxt = hold_full_q;
    ws_nxt        = ws;
    sd_nxt        = sd;
    underrun_nxt  = 1'b0;
    if (fall_c) begin
      ws_nxt = bitcnt_inc_c[BITCNT_W-1];
      sd_nxt = 1'b0;
      if (load_c) begin
        if (hold_full_q) begin
          shreg_nxt     = {hold_l_q, hold_r_q};
          hold_full_nxt = 1'b0;
        end else begin
          shreg_nxt    = '0;
          underrun_nxt = 1'b1;
        end
      end else if ((slot_bit_c >= SLOT_W'(1)) && (slot_bit_c <= SLOT_W'(DATA_W))) begin
        sd_nxt    = shreg_q[2*DATA_W-1];
        shreg_nxt = {shreg_q[2*DATA_W-2:0], 1'b0};
      end
    end
    if (accept_c) begin
      hold_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      bitcnt_q    <= '1;
      ws          <= 1'b1;
      sd          <= 1'b0;
      shreg_q     <= '0;
      hold_full_q <= 1'b0;
      in_ready    <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (fall_c) begin
        bitcnt_q <= bitcnt_inc_c;
      end
      ws          <= ws_nxt;
      sd          <= sd_nxt;
      shreg_q     <= shreg_nxt;
      hold_full_q <= hold_full_nxt;
      in_ready    <= ~hold_full_nxt;
      underrun    <= underrun_nxt;
    end
  end

  // Payload is only meaningful while hold_full_q is set, so it needs no reset.
  always_ff @(posedge CLOCK_50) begin
    if (accept_c) begin
      hold_l_q <= data_left;
      hold_r_q <= data_right;
    end
  end

endmodule

// File: tb/tb_i2s_transmit.sv
// Self-checking bench for i2s_transmit: cycle model with a serial-bit
// scoreboard, a table of back-to-back pairs, and directed corner sequences.
module tb_i2s_transmit;

  localparam int unsigned CLK_DIV = 16;
  localparam int unsigned DW      = 16;
  localparam int unsigned NV      = 5;

  logic          clk        = 1'b0;
  logic          resetn     = 1'b0;
  logic          in_valid   = 1'b0;
  logic [DW-1:0] data_left  = '0;
  logic [DW-1:0] data_right = '0;
  logic          in_ready;
  logic          sck;
  logic          ws;
  logic          sd;
  logic          underrun;

  int checks = 0;
  int errors = 0;

  i2s_transmit #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DW)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_left  (data_left),
    .data_right (data_right),
    .sck        (sck),
    .ws         (ws),
    .sd         (sd),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- cycle model and scoreboard (sampled on negedge) ----------------
  logic          rec_rstn  = 1'b0;
  logic          rec_valid = 1'b0;
  logic [DW-1:0] rec_l     = '0;
  logic [DW-1:0] rec_r     = '0;
  int            n         = 0;
  logic          m_ready   = 1'b0;
  logic          m_under   = 1'b0;
  logic          m_sd      = 1'b0;
  logic          m_ws      = 1'b1;
  logic          m_sck     = 1'b0;
  logic          hold_full = 1'b0;
  logic [DW-1:0] hl        = '0;
  logic [DW-1:0] hr        = '0;
  logic          sdq[$];
  logic [31:0]   word      = '0;
  logic [31:0]   cap_l[$];
  logic [31:0]   cap_r[$];

  always @(negedge clk) begin
    logic acc;
    logic v;
    int   f;
    int   bc;
    int   s;
    if (!rec_rstn) begin
      n = 0; hold_full = 1'b0; m_ready = 1'b0; m_under = 1'b0;
      m_sd = 1'b0; m_ws = 1'b1; m_sck = 1'b0; word = '0;
      sdq.delete(); cap_l.delete(); cap_r.delete();
    end else begin
      acc     = rec_valid && m_ready;
      n       = n + 1;
      m_under = 1'b0;
      m_sck   = ((n / CLK_DIV) % 2) == 1;
      if (n % (2 * CLK_DIV) == 0) begin
        f  = n / (2 * CLK_DIV);
        bc = (f - 1) % 64;
        if (bc == 0) begin
          for (int b = 0; b < 64; b++) begin
            s = b % 32;
            v = 1'b0;
            if (hold_full && s >= 1 && s <= DW)
              v = (b < 32) ? hl[DW-s] : hr[DW-s];
            sdq.push_back(v);
          end
          m_under   = !hold_full;
          hold_full = 1'b0;
        end
        m_ws = (bc >= 32);
        if (sdq.size() == 0) begin
          check("sd_queue_empty", 64'd1, 64'd0);
          m_sd = 1'b0;
        end else begin
          m_sd = sdq.pop_front();
        end
        word = {word[30:0], sd};
        if (bc % 32 == 31) begin
          if (bc >= 32) cap_r.push_back(word);
          else          cap_l.push_back(word);
        end
      end
      if (acc) begin
        hl = rec_l; hr = rec_r; hold_full = 1'b1;
      end
      m_ready = !hold_full;
    end
    check("cyc_in_ready", in_ready, m_ready);
    check("cyc_underrun", underrun, m_under);
    check("cyc_sd", sd, m_sd);
    check("cyc_ws", ws, m_ws);
    check("cyc_sck", sck, m_sck);
    rec_rstn  = resetn;
    rec_valid = in_valid;
    rec_l     = data_left;
    rec_r     = data_right;
  end

  // ---------------- driver helpers ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    resetn = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    logic rdy;
    int   cnt;
    cnt = 0;
    do begin
      rdy = in_ready;
      @(posedge clk); #2;
      cnt++;
    end while (!rdy && cnt < 5000);
    check(name, rdy, 1'b1);
  endtask

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [31:0]   exp_l;
    logic [31:0]   exp_r;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    int guard;
    vecs[0] = '{16'hA5C3, 16'h8001, 32'h52E1_8000, 32'h4000_8000};
    vecs[1] = '{16'h1234, 16'hFEDC, 32'h091A_0000, 32'h7F6E_0000};
    vecs[2] = '{16'hFFFF, 16'h0000, 32'h7FFF_8000, 32'h0000_0000};
    vecs[3] = '{16'h0001, 16'h7FFF, 32'h0000_8000, 32'h3FFF_8000};
    vecs[4] = '{16'h5555, 16'hAAAA, 32'h2AAA_8000, 32'h5555_0000};

    // Back-to-back pairs from the table; each frame carries the next pair.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      data_left  = vecs[i].l;
      data_right = vecs[i].r;
      in_valid   = 1'b1;
      wait_accept("vec_accept");
    end
    in_valid = 1'b0;
    data_left = '0; data_right = '0;
    guard = 0;
    while (cap_r.size() < NV && guard < 12000) begin
      @(posedge clk); #2; guard++;
    end
    check("vec_frames", 64'(cap_r.size() >= NV), 64'd1);
    for (int i = 0; i < NV; i++) begin
      if (i < cap_l.size()) check("vec_left_slot", cap_l[i], vecs[i].exp_l);
      if (i < cap_r.size()) check("vec_right_slot", cap_r[i], vecs[i].exp_r);
    end

    // Reset timing, idle underrun, then accept on the load cycle.
    do_reset();
    @(posedge clk); #2;
    check("rst_ready_cycle1", in_ready, 1'b1);
    repeat (14) @(posedge clk); #2;
    check("rst_sck_cycle15", sck, 1'b0);
    @(posedge clk); #2;
    check("rst_sck_rise16", sck, 1'b1);
    repeat (15) @(posedge clk); #2;
    check("rst_ws_cycle31", ws, 1'b1);
    @(posedge clk); #2;
    check("rst_ws_fall32", ws, 1'b0);
    check("rst_sck_fall32", sck, 1'b0);
    check("idle_underrun32", underrun, 1'b1);
    repeat (2047) @(posedge clk); #2;
    data_left = 16'h0F0F; data_right = 16'hC3A5; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    check("simul_underrun", underrun, 1'b1);
    check("simul_ready_low", in_ready, 1'b0);
    data_left = 16'hDEAD; data_right = 16'hBEEF;
    repeat (4130) @(posedge clk); #2;
    if (cap_l.size() >= 3 && cap_r.size() >= 3) begin
      check("simul_zero_frame_l", cap_l[1], 32'h0);
      check("simul_zero_frame_r", cap_r[1], 32'h0);
      check("simul_next_frame_l", cap_l[2], 32'h0787_8000);
      check("simul_next_frame_r", cap_r[2], 32'h61D2_8000);
    end else begin
      check("simul_frames", 64'(cap_l.size()), 64'd3);
    end

    // Mid-frame reset with a held pair: nothing leaks after release.
    do_reset();
    data_left = 16'hFFFF; data_right = 16'hFFFF; in_valid = 1'b1;
    wait_accept("mid_accept1");
    wait_accept("mid_accept2");
    in_valid = 1'b0;
    guard = 0;
    while (n != 1312 && guard < 3000) begin
      @(posedge clk); #2; guard++;
    end
    check("mid_reach_bc40", 64'(n), 64'd1312);
    resetn = 1'b0;
    @(posedge clk); #2;
    check("mid_rst_sck", sck, 1'b0);
    check("mid_rst_ws", ws, 1'b1);
    check("mid_rst_sd", sd, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_underrun", underrun, 1'b0);
    resetn = 1'b1;
    repeat (32) @(posedge clk); #2;
    check("mid_post_underrun", underrun, 1'b1);
    repeat (2060) @(posedge clk); #2;
    if (cap_l.size() >= 1 && cap_r.size() >= 1) begin
      check("mid_post_frame_l", cap_l[0], 32'h0);
      check("mid_post_frame_r", cap_r[0], 32'h0);
    end else begin
      check("mid_post_frames", 64'(cap_l.size()), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
